// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-pmem arbiter.
//   lc3b_word      : byte address word
//   lc3b_c_line    : one cache line
//   lc3b_arb_state : arbiter FSM states
//   sat_inc        : saturating increment for the starvation counter
package cache_mem_arbiter_pkg;

    localparam int LC3B_WORD_W  = 16;
    localparam int LC3B_LINE_W  = 128;
    localparam int STARVE_CNT_W = 4;    // holds STARVE_LIMIT up to 15

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

    typedef enum logic [1:0] {
        arb_idle,
        arb_serve_i,
        arb_serve_d,
        arb_done
    } lc3b_arb_state;

    function automatic logic [STARVE_CNT_W-1:0] sat_inc(
        input logic [STARVE_CNT_W-1:0] val,
        input logic [STARVE_CNT_W-1:0] lim
    );
        return (val >= lim) ? lim : val + STARVE_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_select.sv
// Combinational priority pick between the I-side and D-side line requests.
// D wins by default; I wins when it is alone or has been passed over
// STARVE_LIMIT times in a row.
//   i_req, d_req : pending requests
//   starve_cnt   : consecutive D grants taken while I was waiting
//   grant_i      : pick the I-cache
//   grant_d      : pick the D-cache (never together with grant_i)
module arbiter_select
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_req,
    input  logic                    d_req,
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    grant_i,
    output logic                    grant_d
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    always_comb begin
        grant_i = i_req && (!d_req || (starve_cnt == LIMIT));
        grant_d = d_req && !grant_i;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the physical-memory line port between the I-cache miss path and the
// D-cache miss/writeback path. One requester is granted at a time; its
// address (and op/wdata for D) are latched and the completion pulse is
// steered back to that requester only. Read data is broadcast to both caches.
//
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   i_mem_read / i_mem_address        : I-cache line read request
//   i_mem_rdata / i_mem_resp          : line data and completion to I-cache
//   d_mem_read / d_mem_write          : D-cache read / writeback request
//   d_mem_address / d_mem_wdata       : D-cache address and writeback line
//   d_mem_rdata / d_mem_resp          : line data and completion to D-cache
//   pmem_read / pmem_write            : physical memory strobes
//   pmem_address / pmem_wdata         : physical memory address / write line
//   pmem_rdata / pmem_resp            : physical memory read line / completion
//
// state        | meaning
// -------------+--------------------------------------------------------
// arb_idle     | no strobes; arbitrate and latch the winner
// arb_serve_i  | pmem read for the I-cache until pmem_resp
// arb_serve_d  | pmem read or write for the D-cache until pmem_resp
// arb_done     | one-cycle turnaround so a not-yet-dropped request is not re-granted
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [LINE_WIDTH-1:0] i_mem_rdata,
    output logic                  i_mem_resp,

    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [LINE_WIDTH-1:0] d_mem_wdata,
    output logic [LINE_WIDTH-1:0] d_mem_rdata,
    output logic                  d_mem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    lc3b_arb_state           state_q;
    lc3b_arb_state           state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    op_write_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read || d_mem_write;

    arbiter_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt_q),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= arb_idle;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == arb_idle) begin
                if (grant_i) begin
                    addr_q       <= i_mem_address;
                    starve_cnt_q <= '0;
                end else if (grant_d) begin
                    addr_q     <= d_mem_address;
                    wdata_q    <= d_mem_wdata;
                    // a writeback wins over a read presented in the same cycle
                    op_write_q <= d_mem_write;
                    // only count D grants that actually made I wait
                    starve_cnt_q <= i_req ? sat_inc(starve_cnt_q, LIMIT) : '0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            arb_idle: begin
                if (grant_i) begin
                    state_d = arb_serve_i;
                end else if (grant_d) begin
                    state_d = arb_serve_d;
                end
            end
            arb_serve_i,
            arb_serve_d: begin
                if (pmem_resp) begin
                    state_d = arb_done;
                end
            end
            arb_done: begin
                state_d = arb_idle;
            end
            default: begin
                state_d = arb_idle;
            end
        endcase
    end

    // Strobes are decoded from the state register alone, so an async reset
    // drops them immediately without waiting for clk.
    always_comb begin
        pmem_read  = (state_q == arb_serve_i) ||
                     ((state_q == arb_serve_d) && !op_write_q);
        pmem_write = (state_q == arb_serve_d) && op_write_q;
        i_mem_resp = (state_q == arb_serve_i) && pmem_resp;
        d_mem_resp = (state_q == arb_serve_d) && pmem_resp;
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_mem_rdata  = pmem_rdata;
    assign d_mem_rdata  = pmem_rdata;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache miss path (fetch) and the D-cache miss/writeback path (LDR/STR/LDB/STB/LDI/STI/TRAP).
- Grants one requester at a time, latches the request, and steers the response back to that requester only.
- Default policy is D-side priority, so memory stages drain first. A starvation counter bounds how long a pending fetch can wait.
- Sits between both caches and pmem, below the pipeline stages that control_rom drives.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits.
- STARVE_LIMIT, 4, maximum consecutive D grants while an I request is pending. Legal range is 1 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_mem_read  in  1  I-cache line read request, held until i_mem_resp.
- i_mem_address  in  ADDR_WIDTH  I-cache line address.
- i_mem_rdata  out  LINE_WIDTH  read line to the I-cache.
- i_mem_resp  out  1  one-cycle completion pulse to the I-cache.
- d_mem_read  in  1  D-cache line read request, held until d_mem_resp.
- d_mem_write  in  1  D-cache line writeback request, held until d_mem_resp.
- d_mem_address  in  ADDR_WIDTH  D-cache line address.
- d_mem_wdata  in  LINE_WIDTH  writeback line.
- d_mem_rdata  out  LINE_WIDTH  read line to the D-cache.
- d_mem_resp  out  1  one-cycle completion pulse to the D-cache.
- pmem_read  out  1  physical memory read.
- pmem_write  out  1  physical memory write.
- pmem_address  out  ADDR_WIDTH  physical memory address.
- pmem_wdata  out  LINE_WIDTH  physical memory write data.
- pmem_rdata  in  LINE_WIDTH  physical memory read data.
- pmem_resp  in  1  physical memory completion pulse.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE; starve_cnt 0; latched address, wdata and op cleared. pmem_read, pmem_write, i_mem_resp and d_mem_resp are 0. pmem_address and pmem_wdata are 0.
- Reset mid-transaction: the transaction is abandoned and the pmem strobes drop immediately (asynchronously). Any pmem_resp arriving after reset is released is ignored.
- States:
  - IDLE: no strobes driven.
  - SERVE_I and SERVE_D: pmem strobes driven from latched registers.
  - DONE: one-cycle turnaround with no grant. This prevents re-granting a request the requester has not yet dropped.
- Arbitration is evaluated in IDLE on registered inputs:
  - d_req = d_mem_read OR d_mem_write; i_req = i_mem_read.
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant I if starve_cnt == STARVE_LIMIT, else grant D.
- On a grant: latch the address (plus op and wdata for D). Move to SERVE_x on the next edge, so pmem strobes assert 1 cycle after the request is seen in IDLE.
- Starvation counter:
  - On a D grant with i_req also high: starve_cnt increments, saturating at STARVE_LIMIT.
  - On any I grant: starve_cnt clears to 0.
  - On a D grant with i_req low: starve_cnt clears to 0.
- D op select: if d_mem_read and d_mem_write are both high, write wins. pmem_write=1 and pmem_read=0. Never assert both pmem strobes.
- SERVE_x:
  - Hold pmem strobes, address and wdata stable until pmem_resp.
  - When pmem_resp=1, assert the matching x_mem_resp combinationally in the same cycle, drop the strobes at the next edge, and go to DONE.
- Read data: i_mem_rdata and d_mem_rdata are driven from pmem_rdata continuously. Only the resp pulses are gated.
- pmem_resp in IDLE or DONE: ignored, and no resp is forwarded.
- DONE always returns to IDLE after 1 cycle.
- Minimum occupancy per transaction is grant cycle + service + DONE. Back-to-back requesters therefore see at least 2 idle pmem cycles between transactions.

Decomposition:
- lc3b_types gains:
  - lc3b_c_line (LINE_WIDTH vector).
  - the enum lc3b_arb_state {arb_idle, arb_serve_i, arb_serve_d, arb_done}.
- One sub-module, arbiter_select: purely combinational priority pick. Inputs are i_req, d_req and starve_cnt; outputs are grant_i and grant_d. It is kept separate so the priority policy can be swapped.
- The FSM, latches and counter live in cache_mem_arbiter.

Test Plan:
- Reset mid-transaction: D write in flight, pulse reset_n low mid-cycle -> pmem_write falls without waiting for clk. A pmem_resp after release produces no d_mem_resp. State is IDLE.
- Lone I read, addr 0x1230, pmem_resp after 5 cycles with rdata 128'hA5... -> pmem_read at t+1 with address 0x1230. i_mem_resp is 1 for exactly 1 cycle with i_mem_rdata=A5.... d_mem_resp stays 0.
- Simultaneous I read 0x0040 and D write 0x8000 with data 0xDEAD... -> D served first (pmem_write with address 0x8000). I served after DONE and IDLE. starve_cnt becomes 1, then 0.
- D requests continuously held, I pending, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D...; I waits exactly 4 D services.
- d_mem_read and d_mem_write both high at 0x0100 -> pmem_write=1, pmem_read=0 throughout.
- Spurious pmem_resp while IDLE, and a request held high through DONE -> no resp forwarded. The held request is re-granted only from IDLE.
